// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - register map, response codes and FSM states for the AES AXI-Lite control stage
package aes_ctrl_pkg;

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h04;
    localparam logic [5:0] OFF_KEY0   = 6'h10;
    localparam logic [5:0] OFF_DIN0   = 6'h20;
    localparam logic [5:0] OFF_DOUT0  = 6'h30;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_ERR    = 2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} ctrl_state_t;

    typedef enum logic [2:0] {RG_CTRL, RG_STATUS, RG_KEY, RG_DIN, RG_DOUT, RG_NONE} reg_region_t;

    // Word index is byte offset [5:2]; the low two byte-lane bits never select a register.
    function automatic reg_region_t decode_region(input logic [3:0] widx);
        reg_region_t r;
        case (widx[3:2])
            2'd0:    r = (widx[1:0] == 2'd0) ? RG_CTRL :
                         (widx[1:0] == 2'd1) ? RG_STATUS : RG_NONE;
            2'd1:    r = RG_KEY;
            2'd2:    r = RG_DIN;
            default: r = RG_DOUT;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_axil_ctrl.sv
// rtl/aes_axil_ctrl.sv - AXI4-Lite register stage that loads key/block, launches the AES core and captures its result
// Optional done/error interrupt output enabled by defining AES_CTRL_IRQ_EN.
module aes_axil_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_TIMEOUT          = 1024
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [127:0]                  core_key,
    output logic [127:0]                  core_din,
    output logic                          core_in_valid,
    input  logic                          core_in_ready,
    input  logic                          core_out_valid,
    input  logic [127:0]                  core_dout,
    output logic                          irq
);

    localparam int CNT_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (C_TIMEOUT > 0) ? CNT_W'(C_TIMEOUT - 1) : '0;

    ctrl_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic        r_awready, r_bvalid, r_arready, r_rvalid, r_core_in_valid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;
    logic        r_done, r_err;
    logic [31:0] r_key [4];
    logic [31:0] r_din [4];
    logic [31:0] r_dout [4];

    logic        w_busy, w_wr_fire, w_rd_fire, w_start_bit, w_launch, w_wr_err;
    logic        w_w1c_done, w_w1c_err, w_core_done, w_tmo, w_done_nxt, w_err_nxt;
    logic        w_irq_en, w_ctrl_we;
    logic [31:0] w_rdata;
    logic [1:0]  w_rresp;
    reg_region_t w_wreg, w_rreg;
    logic        w_unused;

    assign w_unused = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Any address bit above the 64-byte window makes the access unmapped.
    assign w_wreg = ((S_AXI_AWADDR >> 6) == '0) ? decode_region(S_AXI_AWADDR[5:2]) : RG_NONE;
    assign w_rreg = ((S_AXI_ARADDR >> 6) == '0) ? decode_region(S_AXI_ARADDR[5:2]) : RG_NONE;

    assign w_busy      = (r_state != IDLE);
    assign w_wr_fire   = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_fire   = r_arready & S_AXI_ARVALID;
    assign w_start_bit = S_AXI_WSTRB[0] & S_AXI_WDATA[CTRL_START];
    assign w_launch    = w_wr_fire & (w_wreg == RG_CTRL) & w_start_bit & ~w_busy;
    assign w_ctrl_we   = w_wr_fire & (w_wreg == RG_CTRL) & S_AXI_WSTRB[0] & ~(w_busy & w_start_bit);
    assign w_wr_err    = (w_wreg == RG_NONE) |
                         (w_busy & ((w_wreg == RG_KEY) | (w_wreg == RG_DIN) |
                                    ((w_wreg == RG_CTRL) & w_start_bit)));

    assign w_w1c_done  = w_wr_fire & (w_wreg == RG_STATUS) & S_AXI_WSTRB[0] & S_AXI_WDATA[STAT_DONE];
    assign w_w1c_err   = w_wr_fire & (w_wreg == RG_STATUS) & S_AXI_WSTRB[0] & S_AXI_WDATA[STAT_ERR];
    assign w_core_done = (r_state == WAIT) & core_out_valid;
    assign w_tmo       = (r_state == WAIT) & ~core_out_valid & (C_TIMEOUT != 0) & (r_cnt == TMO_LAST);

    // Hardware set beats software clear; a new launch wipes the previous outcome.
    assign w_done_nxt  = w_core_done | (r_done & ~w_w1c_done & ~w_launch);
    assign w_err_nxt   = w_tmo | (r_err & ~w_w1c_err & ~w_launch);

`ifdef AES_CTRL_IRQ_EN
    logic r_irq_en, r_irq, w_irq_en_nxt;
    assign w_irq_en_nxt = w_ctrl_we ? S_AXI_WDATA[CTRL_IRQ_EN] : r_irq_en;
    assign w_irq_en     = r_irq_en;
    assign irq          = r_irq;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= (w_done_nxt | w_err_nxt) & w_irq_en_nxt;
        end
    end
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        w_rresp = AXI_RESP_OKAY;
        case (w_rreg)
            RG_CTRL:   w_rdata[CTRL_IRQ_EN] = w_irq_en;
            RG_STATUS: w_rdata[2:0] = {r_err, r_done, w_busy};
            RG_KEY:    w_rdata = r_key[S_AXI_ARADDR[3:2]];
            RG_DIN:    w_rdata = r_din[S_AXI_ARADDR[3:2]];
            RG_DOUT:   w_rdata = r_dout[S_AXI_ARADDR[3:2]];
            default:   w_rresp = AXI_RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_awready       <= 1'b0;
            r_bvalid        <= 1'b0;
            r_bresp         <= AXI_RESP_OKAY;
            r_arready       <= 1'b0;
            r_rvalid        <= 1'b0;
            r_rdata         <= '0;
            r_rresp         <= AXI_RESP_OKAY;
            r_core_in_valid <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_key[i]  <= '0;
                r_din[i]  <= '0;
                r_dout[i] <= '0;
            end
        end else begin
            r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end

            if (w_wr_fire && !w_busy && w_wreg == RG_KEY)
                r_key[S_AXI_AWADDR[3:2]] <= apply_wstrb(r_key[S_AXI_AWADDR[3:2]], S_AXI_WDATA, S_AXI_WSTRB);
            if (w_wr_fire && !w_busy && w_wreg == RG_DIN)
                r_din[S_AXI_AWADDR[3:2]] <= apply_wstrb(r_din[S_AXI_AWADDR[3:2]], S_AXI_WDATA, S_AXI_WSTRB);

            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;

            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state         <= REQ;
                        r_core_in_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (core_in_ready) begin
                        r_core_in_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_out_valid) begin
                        r_dout[0] <= core_dout[127:96];
                        r_dout[1] <= core_dout[95:64];
                        r_dout[2] <= core_dout[63:32];
                        r_dout[3] <= core_dout[31:0];
                        r_state   <= IDLE;
                    end else if (w_tmo) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign core_in_valid = r_core_in_valid;
    assign core_key      = {r_key[0], r_key[1], r_key[2], r_key[3]};
    assign core_din      = {r_din[0], r_din[1], r_din[2], r_din[3]};

endmodule
